// File: rtl/core_exec_ctrl_if.sv
// Execute-stage signal bundle: decode handshake, ALU resolution, memory handshake,
// multi-cycle unit control and fetch redirect.
// Handshake rule: a beat transfers on a posedge where valid and ready are both high;
// valid never depends on ready, and once raised, valid holds with stable payload until the transfer.
interface core_exec_ctrl_if;
    logic        i_de_valid;
    logic        o_de_ready;
    logic        i_de_jump;
    logic        i_de_branch;
    logic        i_de_multi;
    logic        i_alu_pc_src;
    logic [29:0] i_alu_pc_target;
    logic        o_ex_valid;
    logic        o_mem_valid;
    logic        i_mem_ready;
    logic        o_mu_start;
    logic        i_mu_done;
    logic        o_flush;
    logic        o_redirect_valid;
    logic [29:0] o_redirect_pc;
    logic        i_redirect_ack;
    logic        o_wdt_err;

    modport slave (
        input  i_de_valid, i_de_jump, i_de_branch, i_de_multi,
        input  i_alu_pc_src, i_alu_pc_target, i_mem_ready, i_mu_done, i_redirect_ack,
        output o_de_ready, o_ex_valid, o_mem_valid, o_mu_start,
        output o_flush, o_redirect_valid, o_redirect_pc, o_wdt_err
    );

    modport master (
        output i_de_valid, i_de_jump, i_de_branch, i_de_multi,
        output i_alu_pc_src, i_alu_pc_target, i_mem_ready, i_mu_done, i_redirect_ack,
        input  o_de_ready, o_ex_valid, o_mem_valid, o_mu_start,
        input  o_flush, o_redirect_valid, o_redirect_pc, o_wdt_err
    );
endinterface

// File: rtl/core_exec_ctrl.sv
// Execute-stage sequencer: single exec slot, branch/jump redirect with flush and kill window,
// multi-cycle parking. Optional multi-cycle watchdog enabled by defining CORE_EXEC_WDT_EN.
module core_exec_ctrl #(
    parameter int P_KILL_CNT   = 2,
    parameter int P_WDT_CYCLES = 64
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    core_exec_ctrl_if.slave  bus,
    output logic [1:0]       o_dbg_state
);
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MULTI = 2'd1,
        S_REDIR = 2'd2,
        S_KILL  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        r_valid;
    logic        r_jump;
    logic        r_branch;
    logic        r_multi;
    logic        r_flush;
    logic        r_out_en;
    logic [29:0] r_pc;
    logic [3:0]  r_kill_cnt;

    logic        accept;
    logic        retire;
    logic        redir_trig;
    logic        mu_done_eff;

    always_comb begin
        state_nxt        = state;
        bus.o_de_ready   = 1'b0;
        bus.o_mem_valid  = 1'b0;
        bus.o_mu_start   = 1'b0;
        retire           = 1'b0;
        redir_trig       = 1'b0;
        case (state)
            S_RUN: begin
                bus.o_mem_valid = r_valid & !r_multi;
                retire          = bus.o_mem_valid & bus.i_mem_ready;
                redir_trig      = retire & (r_jump | r_branch) & bus.i_alu_pc_src;
                bus.o_mu_start  = r_valid & r_multi;
                // r_out_en keeps every output at 0 for the first cycle out of reset
                bus.o_de_ready  = r_out_en & (!r_valid | (retire & !redir_trig));
                if (redir_trig)
                    state_nxt = S_REDIR;
                else if (r_valid & r_multi)
                    state_nxt = S_MULTI;
            end
            S_MULTI: begin
                if (mu_done_eff)
                    state_nxt = S_RUN;
            end
            S_REDIR: begin
                if (bus.i_redirect_ack)
                    state_nxt = (P_KILL_CNT == 0) ? S_RUN : S_KILL;
            end
            S_KILL: begin
                bus.o_de_ready = 1'b1;
                if (r_kill_cnt <= 4'd1)
                    state_nxt = S_RUN;
            end
            default: state_nxt = S_RUN;
        endcase
    end

    assign accept               = bus.i_de_valid & bus.o_de_ready & (state == S_RUN);
    assign bus.o_ex_valid       = r_valid;
    assign bus.o_flush          = r_flush;
    assign bus.o_redirect_valid = (state == S_REDIR);
    assign bus.o_redirect_pc    = r_pc;
    assign o_dbg_state          = state;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state      <= S_RUN;
            r_valid    <= 1'b0;
            r_jump     <= 1'b0;
            r_branch   <= 1'b0;
            r_multi    <= 1'b0;
            r_flush    <= 1'b0;
            r_out_en   <= 1'b0;
            r_pc       <= 30'd0;
            r_kill_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            r_out_en <= 1'b1;
            r_flush  <= redir_trig;
            if (redir_trig)
                r_pc <= bus.i_alu_pc_target;

            // Multi-cycle ops never carry control-flow flags
            if (accept) begin
                r_valid  <= 1'b1;
                r_multi  <= bus.i_de_multi;
                r_jump   <= bus.i_de_jump & !bus.i_de_multi;
                r_branch <= bus.i_de_branch & !bus.i_de_multi;
            end else if (retire) begin
                r_valid  <= 1'b0;
                r_multi  <= 1'b0;
                r_jump   <= 1'b0;
                r_branch <= 1'b0;
            end else if (mu_done_eff) begin
                r_multi <= 1'b0;
            end

            if (state == S_REDIR && bus.i_redirect_ack)
                r_kill_cnt <= 4'(P_KILL_CNT);
            else if (state == S_KILL && r_kill_cnt != 4'd0)
                r_kill_cnt <= r_kill_cnt - 4'd1;
        end
    end

`ifdef CORE_EXEC_WDT_EN
    logic [15:0] r_wdt_cnt;
    logic        r_wdt_err;
    logic        wdt_fire;

    // Fires in the P_WDT_CYCLES-th cycle spent in S_MULTI without a done
    assign wdt_fire      = (state == S_MULTI) & !bus.i_mu_done
                           & (r_wdt_cnt == 16'(P_WDT_CYCLES - 1));
    assign mu_done_eff   = (state == S_MULTI) & (bus.i_mu_done | wdt_fire);
    assign bus.o_wdt_err = r_wdt_err;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wdt_cnt <= 16'd0;
            r_wdt_err <= 1'b0;
        end else begin
            if (state == S_MULTI && !mu_done_eff)
                r_wdt_cnt <= r_wdt_cnt + 16'd1;
            else
                r_wdt_cnt <= 16'd0;
            if (wdt_fire)
                r_wdt_err <= 1'b1;
        end
    end
`else
    assign mu_done_eff   = (state == S_MULTI) & bus.i_mu_done;
    // Constant 0 for any legal limit; keeps the parameter referenced in this build
    assign bus.o_wdt_err = (P_WDT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_core_exec_ctrl.sv
// Directed bench for core_exec_ctrl: throughput, taken/not-taken branch, multi-cycle,
// memory stall, reset mid-redirect and the watchdog (when CORE_EXEC_WDT_EN is defined).
module tb_core_exec_ctrl;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         n_checks = 0;
    int         n_pass   = 0;

    core_exec_ctrl_if bus();

    core_exec_ctrl #(
        .P_KILL_CNT   (2),
        .P_WDT_CYCLES (8)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after posedge, outputs checked at negedge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_de_valid      = 1'b0;
        bus.i_de_jump       = 1'b0;
        bus.i_de_branch     = 1'b0;
        bus.i_de_multi      = 1'b0;
        bus.i_alu_pc_src    = 1'b0;
        bus.i_alu_pc_target = 30'd0;
        bus.i_mem_ready     = 1'b1;
        bus.i_mu_done       = 1'b0;
        bus.i_redirect_ack  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, bus.o_de_ready, 0);
        check({tag, "_exv"},   bus.o_ex_valid, 0);
        check({tag, "_memv"},  bus.o_mem_valid, 0);
        check({tag, "_start"}, bus.o_mu_start, 0);
        check({tag, "_flush"}, bus.o_flush, 0);
        check({tag, "_rdv"},   bus.o_redirect_valid, 0);
        check({tag, "_rdpc"},  bus.o_redirect_pc, 0);
        check({tag, "_wdt"},   bus.o_wdt_err, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        look();
        check_all_zero("rst");
        rst_n = 1'b1;
        tick();
        look();
        check("rst_rel_ready", bus.o_de_ready, 1);

        // Back-to-back ALU ops
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.i_de_valid = 1'b1;
            look();
            check($sformatf("b2b_ready%0d", i), bus.o_de_ready, 1);
            check($sformatf("b2b_memv%0d", i), bus.o_mem_valid, (i > 0) ? 1 : 0);
        end
        tick();
        bus.i_de_valid = 1'b0;
        look();
        check("b2b_memv4", bus.o_mem_valid, 1);
        tick();
        look();
        check("b2b_empty_memv", bus.o_mem_valid, 0);
        check("b2b_empty_exv", bus.o_ex_valid, 0);

        // Taken branch: flush, redirect held until ack, two kill cycles
        tick();
        bus.i_de_valid  = 1'b1;
        bus.i_de_branch = 1'b1;
        tick();
        bus.i_de_valid      = 1'b0;
        bus.i_de_branch     = 1'b0;
        bus.i_alu_pc_src    = 1'b1;
        bus.i_alu_pc_target = 30'h0000_0040;
        look();
        check("br_memv", bus.o_mem_valid, 1);
        check("br_trig_ready", bus.o_de_ready, 0);
        check("br_trig_flush", bus.o_flush, 0);
        tick();
        bus.i_alu_pc_src    = 1'b0;
        bus.i_alu_pc_target = 30'h3fff_ffff;
        look();
        check("br_state_redir", dbg_state, 2);
        check("br_flush", bus.o_flush, 1);
        check("br_rdv0", bus.o_redirect_valid, 1);
        check("br_rdpc0", bus.o_redirect_pc, 30'h40);
        check("br_ready_redir", bus.o_de_ready, 0);
        check("br_exv_clear", bus.o_ex_valid, 0);
        tick();
        look();
        check("br_flush_once", bus.o_flush, 0);
        check("br_rdv1", bus.o_redirect_valid, 1);
        check("br_rdpc1", bus.o_redirect_pc, 30'h40);
        tick();
        bus.i_redirect_ack = 1'b1;
        look();
        check("br_rdv2", bus.o_redirect_valid, 1);
        check("br_rdpc2", bus.o_redirect_pc, 30'h40);
        tick();
        bus.i_redirect_ack = 1'b0;
        bus.i_de_valid     = 1'b1;
        look();
        check("kill0_state", dbg_state, 3);
        check("kill0_rdv", bus.o_redirect_valid, 0);
        check("kill0_ready", bus.o_de_ready, 1);
        check("kill0_memv", bus.o_mem_valid, 0);
        tick();
        look();
        check("kill1_state", dbg_state, 3);
        check("kill1_ready", bus.o_de_ready, 1);
        check("kill1_exv", bus.o_ex_valid, 0);
        tick();
        bus.i_de_valid = 1'b0;
        look();
        check("kill_done_state", dbg_state, 0);
        check("kill_done_exv", bus.o_ex_valid, 0);
        check("kill_done_memv", bus.o_mem_valid, 0);

        // Not-taken branch: next instruction accepted in the retire cycle
        tick();
        bus.i_de_valid  = 1'b1;
        bus.i_de_branch = 1'b1;
        tick();
        bus.i_de_branch     = 1'b0;
        bus.i_alu_pc_target = 30'h0000_0040;
        look();
        check("nt_memv", bus.o_mem_valid, 1);
        check("nt_ready", bus.o_de_ready, 1);
        tick();
        bus.i_de_valid = 1'b0;
        look();
        check("nt_flush", bus.o_flush, 0);
        check("nt_rdv", bus.o_redirect_valid, 0);
        check("nt_next_memv", bus.o_mem_valid, 1);
        tick();
        look();
        check("nt_empty", bus.o_ex_valid, 0);

        // Multi-cycle op, done 5 cycles after start
        tick();
        bus.i_de_valid = 1'b1;
        bus.i_de_multi = 1'b1;
        tick();
        bus.i_de_multi = 1'b0;
        look();
        check("mu_start", bus.o_mu_start, 1);
        check("mu_start_ready", bus.o_de_ready, 0);
        check("mu_start_memv", bus.o_mem_valid, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            look();
            check($sformatf("mu_wait_state%0d", i), dbg_state, 1);
            check($sformatf("mu_wait_start%0d", i), bus.o_mu_start, 0);
            check($sformatf("mu_wait_ready%0d", i), bus.o_de_ready, 0);
        end
        tick();
        bus.i_mu_done = 1'b1;
        look();
        check("mu_done_ready", bus.o_de_ready, 0);
        tick();
        bus.i_mu_done = 1'b0;
        look();
        check("mu_res_memv", bus.o_mem_valid, 1);
        check("mu_res_start", bus.o_mu_start, 0);
        check("mu_res_ready", bus.o_de_ready, 1);
        tick();
        bus.i_de_valid = 1'b0;
        look();
        check("mu_next_memv", bus.o_mem_valid, 1);
        tick();
        look();
        check("mu_empty", bus.o_ex_valid, 0);

        // Memory stall on a taken jump
        tick();
        bus.i_de_valid = 1'b1;
        bus.i_de_jump  = 1'b1;
        tick();
        bus.i_de_valid      = 1'b0;
        bus.i_de_jump       = 1'b0;
        bus.i_mem_ready     = 1'b0;
        bus.i_alu_pc_src    = 1'b1;
        bus.i_alu_pc_target = 30'h0000_0123;
        for (int i = 0; i < 3; i++) begin
            look();
            check($sformatf("stall_memv%0d", i), bus.o_mem_valid, 1);
            check($sformatf("stall_rdv%0d", i), bus.o_redirect_valid, 0);
            check($sformatf("stall_flush%0d", i), bus.o_flush, 0);
            tick();
        end
        bus.i_mem_ready     = 1'b1;
        bus.i_alu_pc_target = 30'h0000_02aa;
        look();
        check("stall_ret_memv", bus.o_mem_valid, 1);
        tick();
        bus.i_alu_pc_src = 1'b0;
        look();
        check("jmp_rdv", bus.o_redirect_valid, 1);
        check("jmp_rdpc", bus.o_redirect_pc, 30'h2aa);
        check("jmp_flush", bus.o_flush, 1);

        // Reset while in S_REDIR
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        look();
        check_all_zero("redir_rst");
        tick();
        look();
        check("redir_rst_ready", bus.o_de_ready, 1);

        // Multi with jump flag: treated as multi, no redirect
        tick();
        bus.i_de_valid   = 1'b1;
        bus.i_de_multi   = 1'b1;
        bus.i_de_jump    = 1'b1;
        bus.i_alu_pc_src = 1'b1;
        tick();
        bus.i_de_valid = 1'b0;
        bus.i_de_multi = 1'b0;
        bus.i_de_jump  = 1'b0;
        look();
        check("mj_start", bus.o_mu_start, 1);
        tick();
        bus.i_mu_done = 1'b1;
        look();
        check("mj_state", dbg_state, 1);
        tick();
        bus.i_mu_done = 1'b0;
        look();
        check("mj_memv", bus.o_mem_valid, 1);
        tick();
        bus.i_alu_pc_src = 1'b0;
        look();
        check("mj_rdv", bus.o_redirect_valid, 0);
        check("mj_flush", bus.o_flush, 0);
        check("mj_state_run", dbg_state, 0);

        // Multi-cycle op with no done
        tick();
        bus.i_de_valid = 1'b1;
        bus.i_de_multi = 1'b1;
        tick();
        bus.i_de_valid = 1'b0;
        bus.i_de_multi = 1'b0;
        look();
        check("wd_start", bus.o_mu_start, 1);
`ifdef CORE_EXEC_WDT_EN
        for (int i = 1; i <= 8; i++) begin
            tick();
            look();
            check($sformatf("wd_state%0d", i), dbg_state, 1);
            check($sformatf("wd_err%0d", i), bus.o_wdt_err, 0);
        end
        tick();
        look();
        check("wd_forced_state", dbg_state, 0);
        check("wd_forced_memv", bus.o_mem_valid, 1);
        check("wd_err_set", bus.o_wdt_err, 1);
        tick();
        tick();
        look();
        check("wd_err_sticky", bus.o_wdt_err, 1);
        check("wd_empty", bus.o_ex_valid, 0);
`else
        for (int i = 1; i <= 12; i++) begin
            tick();
            look();
            check($sformatf("nowd_state%0d", i), dbg_state, 1);
            check($sformatf("nowd_err%0d", i), bus.o_wdt_err, 0);
        end
        tick();
        bus.i_mu_done = 1'b1;
        tick();
        bus.i_mu_done = 1'b0;
        look();
        check("nowd_memv", bus.o_mem_valid, 1);
        check("nowd_err_end", bus.o_wdt_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
